// File: rtl/rapids_alu_pkg.sv
// Shared definitions for the Rapids ALU request sequencer: op codes,
// precision encoding and the dispatch FSM state encoding.
package rapids_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_FMA = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b111;

  typedef enum logic [1:0] {
    PREC_CHAR   = 2'd0,
    PREC_HALF   = 2'd1,
    PREC_FULL   = 2'd2,
    PREC_DOUBLE = 2'd3
  } precision_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dispatch_state_e;

  // Multiply-class ops use the long operand hold time.
  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_FMA);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op classification: multiply-class latency select and
// support check against the build-time op mask.
module alu_op_decode
  import rapids_alu_pkg::*;
#(
  parameter logic [7:0] OP_MASK = 8'h11
) (
  input  logic [2:0] op,
  output logic       is_mul_class,
  output logic       supported
);

  assign is_mul_class = is_mul_op(op);
  assign supported    = OP_MASK[op];

endmodule

// File: rtl/alu_dispatch.sv
// Request-side sequencer for the Rapids combinational ALU: registers operands,
// holds them for the op latency, and returns Y1/Y2 with the caller's tag.
module alu_dispatch
  import rapids_alu_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter int         TAG_W   = 4,
  parameter int         ALU_LAT = 1,
  parameter int         MUL_LAT = 3,
  parameter logic [7:0] OP_MASK = 8'h11
) (
  input  logic             clk,
  input  logic             rst,

  // Valid/ready on both channels: a beat transfers on a rising edge where
  // valid and ready are both high; valid never depends on ready.
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_floating,
  input  logic             req_form,
  input  logic [1:0]       req_precision,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_c,
  input  logic [WIDTH-1:0] req_d,
  input  logic [TAG_W-1:0] req_tag,

  output logic [2:0]       alu_op,
  output logic             alu_floating,
  output logic             alu_form,
  output logic [1:0]       alu_precision,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_c,
  output logic [WIDTH-1:0] alu_d,
  input  logic [WIDTH-1:0] alu_y1,
  input  logic [WIDTH-1:0] alu_y2,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y1,
  output logic [WIDTH-1:0] rsp_y2,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,

  output logic             busy
);

  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

  dispatch_state_e  state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [2:0]       alu_op_q, alu_op_d;
  logic             alu_floating_q, alu_floating_d;
  logic             alu_form_q, alu_form_d;
  logic [1:0]       alu_precision_q, alu_precision_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] alu_c_q, alu_c_d;
  logic [WIDTH-1:0] alu_d_q, alu_d_d;

  logic [WIDTH-1:0] rsp_y1_q, rsp_y1_d;
  logic [WIDTH-1:0] rsp_y2_q, rsp_y2_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;

  logic is_mul_class;
  logic supported;
  logic accept;

  alu_op_decode #(
    .OP_MASK (OP_MASK)
  ) u_decode (
    .op           (req_op),
    .is_mul_class (is_mul_class),
    .supported    (supported)
  );

  // Ready is gated by rst so nothing is accepted while reset is asserted.
  assign req_ready = !rst && ((state_q == ST_IDLE) ||
                              ((state_q == ST_RESP) && rsp_ready));
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    tag_d           = tag_q;
    alu_op_d        = alu_op_q;
    alu_floating_d  = alu_floating_q;
    alu_form_d      = alu_form_q;
    alu_precision_d = alu_precision_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    alu_c_d         = alu_c_q;
    alu_d_d         = alu_d_q;
    rsp_y1_d        = rsp_y1_q;
    rsp_y2_d        = rsp_y2_q;
    rsp_tag_d       = rsp_tag_q;
    rsp_err_d       = rsp_err_q;

    case (state_q)
      ST_WAIT: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          rsp_y1_d  = alu_y1;
          rsp_y2_d  = alu_y2;
          rsp_tag_d = tag_q;
          rsp_err_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // A new accept overrides the RESP->IDLE retirement, giving back-to-back
    // operation without a bubble cycle.
    if (accept) begin
      if (supported) begin
        alu_op_d        = req_op;
        alu_floating_d  = req_floating;
        alu_form_d      = req_form;
        alu_precision_d = req_precision;
        alu_a_d         = req_a;
        alu_b_d         = req_b;
        alu_c_d         = req_c;
        alu_d_d         = req_d;
        tag_d           = req_tag;
        count_d         = is_mul_class ? MUL_CNT : ALU_CNT;
        state_d         = ST_WAIT;
      end else begin
        // ALU inputs are left untouched so the ALU never sees a glitch.
        rsp_y1_d  = '0;
        rsp_y2_d  = '0;
        rsp_tag_d = req_tag;
        rsp_err_d = 1'b1;
        state_d   = ST_RESP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      count_q         <= '0;
      tag_q           <= '0;
      alu_op_q        <= '0;
      alu_floating_q  <= 1'b0;
      alu_form_q      <= 1'b0;
      alu_precision_q <= '0;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      alu_c_q         <= '0;
      alu_d_q         <= '0;
      rsp_y1_q        <= '0;
      rsp_y2_q        <= '0;
      rsp_tag_q       <= '0;
      rsp_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      tag_q           <= tag_d;
      alu_op_q        <= alu_op_d;
      alu_floating_q  <= alu_floating_d;
      alu_form_q      <= alu_form_d;
      alu_precision_q <= alu_precision_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
      alu_c_q         <= alu_c_d;
      alu_d_q         <= alu_d_d;
      rsp_y1_q        <= rsp_y1_d;
      rsp_y2_q        <= rsp_y2_d;
      rsp_tag_q       <= rsp_tag_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  assign alu_op        = alu_op_q;
  assign alu_floating  = alu_floating_q;
  assign alu_form      = alu_form_q;
  assign alu_precision = alu_precision_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_c         = alu_c_q;
  assign alu_d         = alu_d_q;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_y1    = rsp_y1_q;
  assign rsp_y2    = rsp_y2_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
Request-side sequencer that drives the Rapids combinational ALU port bundle (op, floating, form, precision, A–D in; Y1, Y2 out).
- Accepts one operation at a time on a valid/ready request channel.
- Registers the operands onto the ALU inputs and holds them stable for the op's latency.
- Captures Y1/Y2 and returns them with the caller's tag on a valid/ready response channel.
- Sits between the issue stage and the ALU; it is the only driver of the ALU inputs.

Parameters:
WIDTH, 32, operand/result width
TAG_W, 4, request tag width
ALU_LAT, 1, cycles to hold operands for non-multiply ops (>=1)
MUL_LAT, 3, cycles to hold operands for MUL (010) and FMA (110) (>=1)
OP_MASK, 8'h11, bit i set means op code i is supported (default ADD, SUB)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when high with req_valid
req_op  in  3  ALU op code
req_floating  in  1  floating-point select
req_form  in  1  first/second form select
req_precision  in  2  CHAR/HALF/FULL/DOUBLE
req_a, req_b, req_c, req_d  in  WIDTH each  operands
req_tag  in  TAG_W  caller tag
alu_op, alu_floating, alu_form, alu_precision  out  3/1/1/2  registered ALU controls
alu_a, alu_b, alu_c, alu_d  out  WIDTH each  registered ALU operands
alu_y1, alu_y2  in  WIDTH each  ALU results (combinational from alu_*)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_y1, rsp_y2  out  WIDTH each  captured results
rsp_tag  out  TAG_W  tag of the request
rsp_err  out  1  op unsupported per OP_MASK
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, WAIT, RESP. Encoding lives in the package.
- Reset (async, active-high): state=IDLE, count=0, all outputs 0 (including req_ready, rsp_valid, alu_*, rsp_*). A reset during WAIT/RESP discards the op; no response is produced afterwards.
- req_ready = !rst && (state==IDLE || (state==RESP && rsp_ready)).
- Accept edge T (req_valid && req_ready), supported op:
  - load alu_* from req_*; latch tag.
  - count = lat-1, where lat = MUL_LAT if op in {010,110}, else ALU_LAT.
  - state=WAIT.
- WAIT: decrement count each edge while count != 0. On the edge where count==0:
  - rsp_y1/rsp_y2 <= alu_y1/alu_y2; rsp_tag <= tag; rsp_err=0.
  - state=RESP.
  - Result: rsp_valid rises at edge T+lat.
- Accept edge T, unsupported op (OP_MASK[op]==0):
  - alu_* are not reloaded.
  - rsp_y1=rsp_y2=0, rsp_err=1, rsp_tag=req_tag, state=RESP at edge T (rsp_valid high in the cycle after T).
- RESP: rsp_valid=1. All rsp_* are held stable while !rsp_ready.
  - On rsp_ready with no new request: state=IDLE and rsp_valid falls.
  - On rsp_ready with req_valid on the same edge: response completes and the new request is accepted, going to WAIT or RESP per its op. No bubble.
- alu_* are held unchanged from the accept edge until the next supported accept. Holding them outside WAIT is permitted and required (no glitching of ALU inputs).
- count width is $clog2(max(ALU_LAT,MUL_LAT)+1). A latency of 1 means capture on the first edge after accept.
- busy = (state != IDLE).

Decomposition:
- Package rapids_alu_pkg:
  - op code constants (OP_ADD=000, OP_SUB=100, OP_MUL=010, OP_FMA=110, OP_SHL=001, OP_SHR=011, OP_AND=101, OP_OR=111);
  - precision enum (CHAR, HALF, FULL, DOUBLE);
  - dispatch state enum.
- One sub-module, alu_op_decode (combinational): input op and OP_MASK; outputs is_mul_class and supported. All sequencing stays in alu_dispatch.

Test Plan:
1. Reset: hold rst high 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, alu_a=0. Release -> req_ready=1 the next cycle.
2. ADD (ALU stub Y1=A+C, Y2=B+D): op=000, A=5, B=1, C=7, D=2, tag=3 -> rsp_valid at accept+1, rsp_y1=12, rsp_y2=3, rsp_tag=3, rsp_err=0.
3. MUL, MUL_LAT=3 (stub Y1=A*C): A=6, C=7 -> alu_a=6 stable for 3 cycles, rsp_valid exactly 3 cycles after accept, rsp_y1=42, req_ready=0 meanwhile.
4. Unsupported op=001 with OP_MASK=8'h11, tag=9 -> rsp_valid next cycle, rsp_err=1, rsp_y1=rsp_y2=0, rsp_tag=9, alu_* unchanged from the prior op.
5. Backpressure: rsp_ready=0 for 5 cycles -> rsp_* constant and req_ready=0. Then rsp_ready=1 with an ADD pending -> response retired and new request accepted on the same edge; new rsp_valid one cycle later.
6. Reset mid-op: assert rst during cycle 2 of a MUL -> all outputs 0 immediately. After release, no rsp_valid within 10 cycles unless a new request is issued.
